// File: rtl/lut_config_loader_pkg.sv
// Shared definitions for LUT configuration loaders: FSM states and the
// beat-count arithmetic derived from the LUT size and the beat width.
package lut_config_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
        ST_DONE,
        ST_ERROR
    } cfg_state_e;

    function automatic int calc_nbeats(input int mem_size, input int cfg_width);
        return mem_size / cfg_width;
    endfunction

    function automatic int calc_cnt_w(input int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

    function automatic bit width_divides(input int mem_size, input int cfg_width);
        return (cfg_width > 0) && ((mem_size % cfg_width) == 0);
    endfunction

endpackage

// File: rtl/lut_config_loader_shift_reg.sv
// Right-shift register with enable and synchronous clear; new data enters at
// the top so the first beat shifted in ends up in the lowest slot.
module cfg_shift_reg #(
    parameter int WIDTH = 16,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [SHIFT-1:0] din,
    output logic [WIDTH-1:0] q
);

    generate
        if (WIDTH == SHIFT) begin : g_single
            always_ff @(posedge clk) begin
                if (rst || clr)
                    q <= '0;
                else if (en)
                    q <= din;
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (rst || clr)
                    q <= '0;
                else if (en)
                    q <= {din, q[WIDTH-1:SHIFT]};
            end
        end
    endgenerate

endmodule

// File: rtl/lut_config_loader.sv
// Streams a LUT truth table in as CONFIG_WIDTH-bit beats, checks framing with
// cfg_last, and commits the assembled word to the LUT with a one-cycle cen.
module lut_config_loader
    import lut_config_loader_pkg::*;
#(
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 2 ** INPUTS,
    parameter int CONFIG_WIDTH = 1
) (
    input  logic                    cclk,
    input  logic                    rst,
    input  logic [CONFIG_WIDTH-1:0] cfg_data,
    input  logic                    cfg_valid,
    input  logic                    cfg_last,
    output logic                    cfg_ready,
    input  logic                    cfg_restart,
    output logic [MEM_SIZE-1:0]     config_out,
    output logic                    cen,
    output logic                    done,
    output logic                    error
);

    localparam int NBEATS = calc_nbeats(MEM_SIZE, CONFIG_WIDTH);
    localparam int CNT_W  = calc_cnt_w(NBEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    generate
        if (!width_divides(MEM_SIZE, CONFIG_WIDTH)) begin : g_bad_width
            $error("lut_config_loader: MEM_SIZE must be a multiple of CONFIG_WIDTH");
        end
    endgenerate

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             clr;

    assign accept = cfg_valid && cfg_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr       = 1'b0;
        cfg_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (accept) begin
                    cnt_d = CNT_W'(1);
                    if (NBEATS == 1)
                        state_d = cfg_last ? ST_COMMIT : ST_ERROR;
                    else
                        state_d = cfg_last ? ST_ERROR : ST_LOAD;
                end
            end
            ST_LOAD: begin
                cfg_ready = 1'b1;
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT)
                        state_d = cfg_last ? ST_COMMIT : ST_ERROR;
                    else if (cfg_last)
                        state_d = ST_ERROR;
                end
            end
            ST_COMMIT: state_d = ST_DONE;
            ST_DONE, ST_ERROR: begin
                if (cfg_restart) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status strobes are registered from the next state so they line up
    // exactly with the state they describe and never glitch on inputs.
    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cen     <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cen     <= (state_d == ST_COMMIT);
            done    <= (state_d == ST_DONE);
            error   <= (state_d == ST_ERROR);
        end
    end

    cfg_shift_reg #(
        .WIDTH (MEM_SIZE),
        .SHIFT (CONFIG_WIDTH)
    ) u_shift (
        .clk (cclk),
        .rst (rst),
        .clr (clr),
        .en  (accept),
        .din (cfg_data),
        .q   (config_out)
    );

endmodule

// File: tb/tb_lut_config_loader.sv
// Bench for lut_config_loader: nibble-wide (dut_a) and serial (dut_b) loaders
// driven by directed frames plus randomized framing against a frame model.
module tb_lut_config_loader;

    logic        cclk, rst;
    logic [3:0]  a_cfg_data;
    logic        a_cfg_valid, a_cfg_last, a_cfg_ready, a_cfg_restart;
    logic [15:0] a_config_out;
    logic        a_cen, a_done, a_error;
    logic [0:0]  b_cfg_data;
    logic        b_cfg_valid, b_cfg_last, b_cfg_ready, b_cfg_restart;
    logic [15:0] b_config_out;
    logic        b_cen, b_done, b_error;

    int checks = 0;
    int errors = 0;
    int a_cen_cnt = 0, b_cen_cnt = 0, a_overlap = 0;

    lut_config_loader #(.INPUTS(4), .CONFIG_WIDTH(4)) dut_a (
        .cclk(cclk), .rst(rst), .cfg_data(a_cfg_data), .cfg_valid(a_cfg_valid),
        .cfg_last(a_cfg_last), .cfg_ready(a_cfg_ready), .cfg_restart(a_cfg_restart),
        .config_out(a_config_out), .cen(a_cen), .done(a_done), .error(a_error)
    );

    lut_config_loader #(.INPUTS(4), .CONFIG_WIDTH(1)) dut_b (
        .cclk(cclk), .rst(rst), .cfg_data(b_cfg_data), .cfg_valid(b_cfg_valid),
        .cfg_last(b_cfg_last), .cfg_ready(b_cfg_ready), .cfg_restart(b_cfg_restart),
        .config_out(b_config_out), .cen(b_cen), .done(b_done), .error(b_error)
    );

    initial begin
        cclk = 1'b0;
        forever #5 cclk = ~cclk;
    end

    always @(negedge cclk) begin
        if (a_cen) a_cen_cnt++;
        if (b_cen) b_cen_cnt++;
        if (a_cen && a_error) a_overlap++;
    end

    // Drive one beat starting just after a rising edge; report whether the
    // loader was ready at the edge that consumed it.
    task automatic a_send(input logic [3:0] d, input logic l, output bit acc);
        a_cfg_data = d; a_cfg_valid = 1'b1; a_cfg_last = l;
        @(negedge cclk); acc = a_cfg_ready;
        @(posedge cclk); #1;
        a_cfg_valid = 1'b0; a_cfg_last = 1'b0;
    endtask

    task automatic b_send(input logic d, input logic l, output bit acc);
        b_cfg_data = d; b_cfg_valid = 1'b1; b_cfg_last = l;
        @(negedge cclk); acc = b_cfg_ready;
        @(posedge cclk); #1;
        b_cfg_valid = 1'b0; b_cfg_last = 1'b0;
    endtask

    task automatic a_gap(input int n);
        repeat (n) begin @(posedge cclk); #1; end
    endtask

    task automatic a_restart();
        a_cfg_restart = 1'b1;
        @(posedge cclk); #1;
        a_cfg_restart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_cfg_valid = 1'b1; a_cfg_data = 4'hA; a_cfg_last = 1'b1;
        repeat (2) @(posedge cclk);
        @(negedge cclk);
        checks++; if (a_config_out !== 16'h0) begin errors++; $display("FAIL rst_config_out got %h exp 0000", a_config_out); end
        checks++; if (a_cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", a_cfg_ready); end
        checks++; if ({a_cen, a_done, a_error} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {a_cen, a_done, a_error}); end
        checks++; if ({b_cfg_ready, b_cen, b_done, b_error, b_config_out} !== {4'b1000, 16'h0}) begin errors++; $display("FAIL rst_b got %b %h exp 1000 0000", {b_cfg_ready, b_cen, b_done, b_error}, b_config_out); end
        @(posedge cclk); #1;
        rst = 1'b0; a_cfg_valid = 1'b0; a_cfg_last = 1'b0;
        @(negedge cclk);
        checks++; if (a_config_out !== 16'h0 || a_cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_release got %h %b exp 0000 1", a_config_out, a_cfg_ready); end
        @(posedge cclk); #1;
    endtask

    task automatic test_nominal();
        logic [3:0] b [4] = '{4'h8, 4'h6, 4'h9, 4'h6};
        bit acc;
        int c0 = a_cen_cnt;
        for (int i = 0; i < 4; i++) begin
            a_send(b[i], i == 3, acc);
            checks++; if (!acc) begin errors++; $display("FAIL nom_accept beat %0d got 0 exp 1", i); end
        end
        @(negedge cclk);
        checks++; if ({a_cen, a_done, a_cfg_ready} !== 3'b100) begin errors++; $display("FAIL nom_commit got cen/done/ready %b exp 100", {a_cen, a_done, a_cfg_ready}); end
        checks++; if (a_config_out !== 16'h6968) begin errors++; $display("FAIL nom_word got %h exp 6968", a_config_out); end
        @(negedge cclk);
        checks++; if ({a_cen, a_done, a_cfg_ready} !== 3'b010) begin errors++; $display("FAIL nom_done got cen/done/ready %b exp 010", {a_cen, a_done, a_cfg_ready}); end
        @(posedge cclk); #1;
        a_send(4'hF, 1'b1, acc);
        checks++; if (acc) begin errors++; $display("FAIL nom_done_blocks got ready 1 exp 0"); end
        @(negedge cclk);
        checks++; if (a_config_out !== 16'h6968 || a_done !== 1'b1) begin errors++; $display("FAIL nom_hold got %h %b exp 6968 1", a_config_out, a_done); end
        checks++; if (a_cen_cnt - c0 !== 1) begin errors++; $display("FAIL nom_cen_count got %0d exp 1", a_cen_cnt - c0); end
        @(posedge cclk); #1;
        a_restart();
        @(negedge cclk);
        checks++; if ({a_done, a_cfg_ready, a_config_out} !== {2'b01, 16'h0}) begin errors++; $display("FAIL nom_restart got %b %h exp 01 0000", {a_done, a_cfg_ready}, a_config_out); end
        @(posedge cclk); #1;
    endtask

    task automatic test_gaps();
        logic [3:0] b [4] = '{4'h8, 4'h6, 4'h9, 4'h6};
        bit acc;
        int c0 = a_cen_cnt;
        for (int i = 0; i < 4; i++) begin
            a_send(b[i], i == 3, acc);
            if (i < 3) begin
                a_cfg_data = 4'hF; a_cfg_last = 1'b1;
                a_gap(2);
            end
        end
        @(negedge cclk);
        checks++; if ({a_cen, a_config_out} !== {1'b1, 16'h6968}) begin errors++; $display("FAIL gap_commit got %b %h exp 1 6968", a_cen, a_config_out); end
        @(negedge cclk);
        checks++; if ({a_cen, a_done} !== 2'b01) begin errors++; $display("FAIL gap_done got %b exp 01", {a_cen, a_done}); end
        @(posedge cclk); #1;
        checks++; if (a_cen_cnt - c0 !== 1) begin errors++; $display("FAIL gap_cen_count got %0d exp 1", a_cen_cnt - c0); end
        a_restart();
    endtask

    task automatic test_early_last();
        bit acc;
        int c0 = a_cen_cnt;
        a_send(4'h8, 1'b0, acc);
        a_send(4'h6, 1'b1, acc);
        @(negedge cclk);
        checks++; if ({a_error, a_cen, a_cfg_ready} !== 3'b100) begin errors++; $display("FAIL early_err got err/cen/ready %b exp 100", {a_error, a_cen, a_cfg_ready}); end
        @(posedge cclk); #1;
        checks++; if (a_cen_cnt != c0) begin errors++; $display("FAIL early_no_cen got %0d exp 0", a_cen_cnt - c0); end
        a_restart();
        a_send(4'h8, 1'b0, acc); a_send(4'h6, 1'b0, acc);
        a_send(4'h9, 1'b0, acc); a_send(4'h6, 1'b1, acc);
        repeat (2) @(negedge cclk);
        checks++; if ({a_done, a_error, a_config_out} !== {2'b10, 16'h6968}) begin errors++; $display("FAIL early_recover got %b %h exp 10 6968", {a_done, a_error}, a_config_out); end
        @(posedge cclk); #1;
        a_restart();
    endtask

    task automatic test_missing_last();
        bit acc;
        int c0 = a_cen_cnt;
        a_send(4'h8, 1'b0, acc); a_send(4'h6, 1'b0, acc);
        a_send(4'h9, 1'b0, acc); a_send(4'h6, 1'b0, acc);
        @(negedge cclk);
        checks++; if ({a_error, a_cen, a_config_out} !== {2'b10, 16'h6968}) begin errors++; $display("FAIL miss_err got %b %h exp 10 6968", {a_error, a_cen}, a_config_out); end
        repeat (2) @(negedge cclk);
        checks++; if (a_cen_cnt != c0 || a_done !== 1'b0) begin errors++; $display("FAIL miss_no_cen got cen %0d done %b exp 0 0", a_cen_cnt - c0, a_done); end
        @(posedge cclk); #1;
        a_restart();
    endtask

    task automatic test_reset_mid_frame();
        bit acc;
        int c0 = a_cen_cnt;
        a_send(4'h3, 1'b0, acc); a_send(4'h5, 1'b0, acc);
        rst = 1'b1; a_cfg_valid = 1'b1; a_cfg_data = 4'h7; a_cfg_last = 1'b1;
        @(posedge cclk); #1;
        rst = 1'b0; a_cfg_valid = 1'b0; a_cfg_last = 1'b0;
        @(negedge cclk);
        checks++; if ({a_cfg_ready, a_cen, a_done, a_error, a_config_out} !== {4'b1000, 16'h0}) begin errors++; $display("FAIL rstmid got %b %h exp 1000 0000", {a_cfg_ready, a_cen, a_done, a_error}, a_config_out); end
        @(posedge cclk); #1;
        a_send(4'h8, 1'b0, acc); a_send(4'h6, 1'b0, acc);
        a_send(4'h9, 1'b0, acc); a_send(4'h6, 1'b1, acc);
        repeat (2) @(negedge cclk);
        checks++; if ({a_done, a_config_out} !== {1'b1, 16'h6968} || a_cen_cnt - c0 != 1) begin errors++; $display("FAIL rstmid_recover got %b %h cen %0d exp 1 6968 1", a_done, a_config_out, a_cen_cnt - c0); end
        @(posedge cclk); #1;
        a_restart();
    endtask

    // Frame model: the frame ends at the first beat flagged last, or at the
    // fourth beat; it commits only if that end is the fourth beat and flagged.
    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            logic [3:0]  d [4];
            bit          l [4];
            bit          acc, commit;
            int          t, g, c0;
            logic [15:0] exp_word;
            c0 = a_cen_cnt;
            for (int i = 0; i < 4; i++) begin
                d[i] = 4'($urandom);
                l[i] = (i == 3) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            end
            t = 3;
            for (int i = 2; i >= 0; i--) if (l[i]) t = i;
            commit = (t == 3) && l[3];
            exp_word = '0;
            for (int j = 0; j <= t; j++) exp_word |= 16'(d[j]) << ((3 - t + j) * 4);
            g = $urandom_range(0, 2);
            for (int i = 0; i <= t; i++) begin
                a_send(d[i], l[i], acc);
                checks++; if (!acc) begin errors++; $display("FAIL rnd_accept it %0d beat %0d got 0 exp 1", it, i); end
                if (i < t) a_gap(g);
            end
            @(negedge cclk);
            checks++; if ({a_cen, a_error, a_config_out} !== {commit, !commit, exp_word}) begin errors++; $display("FAIL rnd_result it %0d got %b%b %h exp %b%b %h", it, a_cen, a_error, a_config_out, commit, !commit, exp_word); end
            @(negedge cclk);
            checks++; if (a_done !== commit) begin errors++; $display("FAIL rnd_done it %0d got %b exp %b", it, a_done, commit); end
            @(posedge cclk); #1;
            checks++; if (a_cen_cnt - c0 != int'(commit)) begin errors++; $display("FAIL rnd_cen_count it %0d got %0d exp %0d", it, a_cen_cnt - c0, commit); end
            a_restart();
        end
        checks++; if (a_overlap != 0) begin errors++; $display("FAIL cen_error_overlap got %0d exp 0", a_overlap); end
    endtask

    task automatic test_serial();
        logic [15:0] word = 16'hCAFE;
        bit acc;
        int c0 = b_cen_cnt;
        for (int k = 0; k < 16; k++) begin
            b_send(word[k], k == 15, acc);
            checks++; if (!acc) begin errors++; $display("FAIL ser_accept beat %0d got 0 exp 1", k); end
        end
        @(negedge cclk);
        checks++; if ({b_cen, b_config_out} !== {1'b1, 16'hCAFE}) begin errors++; $display("FAIL ser_commit got %b %h exp 1 cafe", b_cen, b_config_out); end
        @(negedge cclk);
        checks++; if ({b_cen, b_done} !== 2'b01) begin errors++; $display("FAIL ser_done got %b exp 01", {b_cen, b_done}); end
        @(posedge cclk); #1;
        checks++; if (b_cen_cnt - c0 != 1) begin errors++; $display("FAIL ser_cen_count got %0d exp 1", b_cen_cnt - c0); end
    endtask

    initial begin
        rst = 1'b1;
        a_cfg_data = '0; a_cfg_valid = 1'b0; a_cfg_last = 1'b0; a_cfg_restart = 1'b0;
        b_cfg_data = '0; b_cfg_valid = 1'b0; b_cfg_last = 1'b0; b_cfg_restart = 1'b0;
        test_reset();
        test_nominal();
        test_gaps();
        test_early_last();
        test_missing_last();
        test_reset_mid_frame();
        test_random();
        test_serial();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
